// File: rtl/timer_prescaler.sv
// Prescaler tick generator for the timer: divides OSC1 (clk) or the
// synchronized 32768 Hz OSC2 input and issues one-cycle count enables.
module timer_prescaler #(
  parameter int OSC1_BITS = 12,
  parameter int OSC2_BITS = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rt_clk,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        tick_l,
  output logic        tick_h
);

  localparam logic [23:0] ADDR_SCALE = 24'h002018;
  localparam logic [23:0] ADDR_OSC   = 24'h002019;

  logic [7:0]           scale_q;
  logic [7:0]           osc_q;
  logic [OSC1_BITS-1:0] c1_q, c1_d;
  logic [OSC2_BITS-1:0] c2_q, c2_d;
  logic [2:0]           sync_q;
  logic                 edge_q;
  logic                 tick_l_q, tick_h_q;
  logic                 fire_l, fire_h;
  logic                 unused_rd;

  assign unused_rd = bus_read;

  function automatic logic [3:0] k_osc1(input logic [2:0] sel);
    case (sel)
      3'd0:    return 4'd1;
      3'd1:    return 4'd3;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd7;
      3'd5:    return 4'd8;
      3'd6:    return 4'd10;
      default: return 4'd12;
    endcase
  endfunction

  // A channel fires when its divider increments with the low k bits all ones.
  function automatic logic fire(
    input logic                 pre,
    input logic                 src,
    input logic [2:0]           sel,
    input logic                 en1,
    input logic                 en2,
    input logic                 rt_edge,
    input logic [OSC1_BITS-1:0] c1,
    input logic [OSC2_BITS-1:0] c2
  );
    logic [OSC1_BITS-1:0] m1;
    logic [OSC2_BITS-1:0] m2;
    m1 = ~({OSC1_BITS{1'b1}} << k_osc1(sel));
    m2 = ~({OSC2_BITS{1'b1}} << sel);
    if (src)
      return pre & en2 & rt_edge & ((c2 & m2) == m2);
    return pre & en1 & ((c1 & m1) == m1);
  endfunction

  always_comb begin
    c1_d = osc_q[5] ? c1_q + 1'b1 : '0;
    c2_d = c2_q;
    if (!osc_q[4])
      c2_d = '0;
    else if (edge_q)
      c2_d = c2_q + 1'b1;
    fire_l = fire(scale_q[3], osc_q[0], scale_q[2:0],
                  osc_q[5], osc_q[4], edge_q, c1_q, c2_q);
    fire_h = fire(scale_q[7], osc_q[1], scale_q[6:4],
                  osc_q[5], osc_q[4], edge_q, c1_q, c2_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scale_q  <= '0;
      osc_q    <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      sync_q   <= '0;
      edge_q   <= 1'b0;
      tick_l_q <= 1'b0;
      tick_h_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], rt_clk};
      edge_q   <= sync_q[1] & ~sync_q[2];
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      tick_l_q <= fire_l;
      tick_h_q <= fire_h;
      if (bus_write && bus_address_in == ADDR_SCALE)
        scale_q <= bus_data_in;
      if (bus_write && bus_address_in == ADDR_OSC)
        osc_q <= bus_data_in;
    end
  end

  always_comb begin
    bus_data_out = '0;
    if (bus_address_in == ADDR_SCALE)
      bus_data_out = scale_q;
    else if (bus_address_in == ADDR_OSC)
      bus_data_out = osc_q;
  end

  assign tick_l = tick_l_q;
  assign tick_h = tick_h_q;

endmodule

// File: doc/timer_prescaler.md
# timer_prescaler

Tick generator that sits directly upstream of the timer block. It owns the prescaler registers `0x2018` (scale) and `0x2019` (oscillator control). It divides either the system clock (OSC1) or the synchronized real-time 32768 Hz input (OSC2) and issues single-cycle count-enable strobes for the timer's low and high halves. The timer consumes `tick_l`/`tick_h` as its count enables instead of deriving edges itself.

## Interface
Parameters:
- `OSC1_BITS`, default 12: width of the OSC1 free-running divider; must be ≥ 12.
- `OSC2_BITS`, default 7: width of the OSC2 divider; must be ≥ 7.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `rt_clk`  in  1  32768 Hz oscillator, asynchronous to `clk`.
- `bus_write`  in  1  write strobe.
- `bus_read`  in  1  read strobe; not used for decoding, present for bus uniformity.
- `bus_address_in`  in  24  bus address.
- `bus_data_in`  in  8  write data.
- `bus_data_out`  out  8  read data, combinational.
- `tick_l`  out  1  one-cycle count enable for the timer low half (or the full 16-bit timer).
- `tick_h`  out  1  one-cycle count enable for the timer high half.

## Operation
- Register `0x2018` SCALE:
  - [2:0] `sel_l`
  - [3] `pre_en_l`
  - [6:4] `sel_h`
  - [7] `pre_en_h`
- Register `0x2019` OSCCTL:
  - [0] `src_l` (0 = OSC1, 1 = OSC2)
  - [1] `src_h`
  - [4] `osc2_en`
  - [5] `osc1_en`
  - [3:2] and [7:6] are read/write storage with no effect.
- Write: on a rising edge with `bus_write`=1 and the address matching, the register loads `bus_data_in`. The new value governs tick generation from the next edge onward.
- Read: `bus_data_out` is the register value at `0x2018`/`0x2019` and 0 at any other address.
- OSC1 divider `c1` (`OSC1_BITS`):
  - Increments every clk while `osc1_en`=1, wrapping at 2^`OSC1_BITS`.
  - Held at 0 while `osc1_en`=0.
- OSC2 path:
  - `rt_clk` passes through a 2-flop synchronizer, then a third flop for rising-edge detect, producing `rt_edge`.
  - Divider `c2` (`OSC2_BITS`) increments on `rt_edge` while `osc2_en`=1, and is held at 0 while `osc2_en`=0.
- Exponent table (ratio = 2^k), per `sel` value 0..7:
  - OSC1: k = 1, 3, 5, 6, 7, 8, 10, 12 (ratios 2, 8, 32, 64, 128, 256, 1024, 4096).
  - OSC2: k = 0, 1, 2, 3, 4, 5, 6, 7 (ratios 1 to 128).
- Channel x ∈ {l, h} fires when all of the following hold in a cycle:
  - `pre_en_x`=1;
  - the selected source is enabled;
  - the selected divider increments this cycle;
  - its low k bits are all ones before the increment.
  - For k=0 this reduces to "fires on every increment."
- `tick_x` is registered: it is high exactly one cycle, the cycle after the firing condition.
- The two channels are independent. They share dividers, so equal settings produce coincident ticks.
- Changing `sel`/`src` mid-count does not reset the dividers; the next tick is at the next alignment of the new k.

## Timing
- Reset values:
  - SCALE = 0, OSCCTL = 0.
  - `c1` = 0, `c2` = 0.
  - Synchronizer flops = 0.
  - `tick_l` = 0, `tick_h` = 0.
  - `bus_data_out` = 0 for unmatched addresses.
- OSC1 ratio R, enabled from reset release:
  - First `tick_x` is high in cycle R+1 after the first counting edge (1 cycle of register latency).
  - Thereafter the tick period is exactly R cycles.
- OSC2 latency: a `rt_clk` rise sampled at edge n gives `rt_edge` at edge n+2 and `tick` at edge n+3 (ratio 1).
- A write clearing `pre_en_x`, or the selected source enable, at edge n suppresses any tick whose firing condition is at edge ≥ n+1. A tick already registered at edge n still appears.
- Asserting `reset` mid-operation immediately (asynchronously) forces both ticks low and all counters and registers to 0.
- `rt_clk` pulses shorter than 2 clk periods are not guaranteed to be detected. At 32768 Hz vs 4 MHz this condition does not arise.

## Test plan
- Reset readback: after reset, read `0x2018`, `0x2019`, `0x2000` → all return 0x00. Write 0xA5 to `0x2018` and 0x33 to `0x2019` → reads return 0xA5 and 0x33.
- OSC1 fastest: OSCCTL=0x20, SCALE=0x08 (`sel_l`=0, `pre_en_l`=1) → `tick_l` high one cycle every 2 clk, `tick_h` stays 0. Set SCALE=0x0F → period 4096 cycles.
- OSC2 ratio 1: OSCCTL=0x13, SCALE=0x88 → each `rt_clk` rise yields exactly one `tick_l` and one `tick_h`, coincident, 3 clk after the sampled rise. SCALE=0xB8 (`sel_h`=3) → `tick_h` on every 8th `rt_clk` rise.
- Mixed sources: OSCCTL=0x32 (`src_h`=OSC2, `src_l`=OSC1), SCALE=0x8B (`sel_l`=3) → `tick_l` period 64 clk, while `tick_h` follows `rt_clk` edges independently.
- Disable mid-run: with `tick_l` running at ratio 2, clear `osc1_en` → at most one further `tick_l`, then none. Re-enable → `c1` restarts from 0 and the first tick follows the cycle-R+1 rule.
- Reset mid-operation: assert `reset` while ticks are active → ticks drop without waiting for a clock edge and registers read 0 after release. With no further writes, no ticks occur.
